// File: rtl/ni_param.sv
// Parametrised processor <-> NoC network interface: word-to-flit packetiser (TX)
// and flit-to-word depacketiser with an RX word FIFO.
module ni_param #(
  parameter int                         DATA_W   = 32,
  parameter int                         FLIT_W   = 8,
  parameter int                         ADDR_W   = 2,
  parameter logic [FLIT_W-ADDR_W-1:0]   HDR_TAG  = 6'b101111,
  parameter int                         RX_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] dest_add,
  input  logic [DATA_W-1:0] data_in,
  input  logic              proc_valid,
  output logic              proc_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] data_dest,
  output logic              data_valid,
  input  logic              proc_ready_in,
  input  logic [FLIT_W-1:0] flit_in,
  input  logic              flit_in_valid,
  output logic              flit_in_ready,
  output logic [FLIT_W-1:0] flit_out,
  output logic              flit_valid,
  input  logic              noc_ready,
  output logic              err_hdr,
  output logic              err_tail
);

  localparam int NB = DATA_W / FLIT_W;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam int AW = $clog2(RX_DEPTH);
  localparam int EW = ADDR_W + DATA_W;
  localparam logic [CW-1:0]     LAST  = CW'(NB - 1);
  localparam logic [AW:0]       DEPTH = (AW + 1)'(RX_DEPTH);
  localparam logic [FLIT_W-1:0] TAIL  = '1;

  localparam logic [1:0] T_IDLE = 2'd0;
  localparam logic [1:0] T_HEAD = 2'd1;
  localparam logic [1:0] T_BODY = 2'd2;
  localparam logic [1:0] T_TAIL = 2'd3;

  localparam logic [1:0] R_HEAD = 2'd0;
  localparam logic [1:0] R_BODY = 2'd1;
  localparam logic [1:0] R_TAIL = 2'd2;

  logic [1:0]        tx_state_r, tx_state_s;
  logic [CW-1:0]     tx_cnt_r, tx_cnt_s;
  logic [DATA_W-1:0] tx_word_r, tx_word_s;
  logic [ADDR_W-1:0] tx_dest_r, tx_dest_s;
  logic [FLIT_W-1:0] tx_flit_s, flit_out_r;
  logic              flit_valid_r, proc_ready_r;

  logic [1:0]        rx_state_r, rx_state_s;
  logic [CW-1:0]     rx_cnt_r;
  logic [DATA_W-1:0] rx_asm_r;
  logic [ADDR_W-1:0] rx_addr_r;
  logic              err_hdr_r, err_tail_r, flit_in_ready_r;
  logic              rx_xfer_s, hdr_ok_s, push_s, pop_s, full_s;

  logic [EW-1:0]     mem_r [RX_DEPTH];
  logic [AW:0]       wp_r, rp_r, wp_s, rp_s;
  logic [EW-1:0]     push_entry_s, head_s;
  logic [DATA_W-1:0] data_out_r;
  logic [ADDR_W-1:0] data_dest_r;
  logic              data_valid_r;

  // TX next-state: word latch, flit sequencing, stall on !noc_ready
  always_comb begin
    tx_state_s = tx_state_r;
    tx_cnt_s   = tx_cnt_r;
    tx_word_s  = tx_word_r;
    tx_dest_s  = tx_dest_r;
    case (tx_state_r)
      T_IDLE: begin
        if (proc_valid) begin
          tx_word_s  = data_in;
          tx_dest_s  = dest_add;
          tx_state_s = T_HEAD;
        end else begin
          tx_state_s = T_IDLE;
        end
      end
      T_HEAD: begin
        if (noc_ready) begin
          tx_state_s = T_BODY;
          tx_cnt_s   = '0;
        end else begin
          tx_state_s = T_HEAD;
        end
      end
      T_BODY: begin
        if (noc_ready && (tx_cnt_r == LAST)) begin
          tx_state_s = T_TAIL;
        end else if (noc_ready) begin
          tx_cnt_s = tx_cnt_r + 1'b1;
        end else begin
          tx_state_s = T_BODY;
        end
      end
      T_TAIL: begin
        if (noc_ready) begin
          tx_state_s = T_IDLE;
        end else begin
          tx_state_s = T_TAIL;
        end
      end
      default: tx_state_s = T_IDLE;
    endcase
  end

  // Flit presented in the next cycle, derived from the next TX state
  always_comb begin
    tx_flit_s = '0;
    case (tx_state_s)
      T_HEAD:  tx_flit_s = {HDR_TAG, tx_dest_s};
      T_BODY:  tx_flit_s = tx_word_s[FLIT_W*tx_cnt_s +: FLIT_W];
      T_TAIL:  tx_flit_s = TAIL;
      default: tx_flit_s = '0;
    endcase
  end

  // TX state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_r   <= T_IDLE;
      tx_cnt_r     <= '0;
      tx_word_r    <= '0;
      tx_dest_r    <= '0;
      flit_out_r   <= '0;
      flit_valid_r <= 1'b0;
      proc_ready_r <= 1'b1;
    end else begin
      tx_state_r   <= tx_state_s;
      tx_cnt_r     <= tx_cnt_s;
      tx_word_r    <= tx_word_s;
      tx_dest_r    <= tx_dest_s;
      flit_out_r   <= tx_flit_s;
      flit_valid_r <= (tx_state_s != T_IDLE);
      proc_ready_r <= (tx_state_s == T_IDLE);
    end
  end

  assign rx_xfer_s    = flit_in_valid && flit_in_ready_r;
  assign hdr_ok_s     = (flit_in[FLIT_W-1:ADDR_W] == HDR_TAG);
  assign push_s       = rx_xfer_s && (rx_state_r == R_TAIL) && (flit_in == TAIL);
  assign pop_s        = data_valid_r && proc_ready_in;
  assign wp_s         = wp_r + (AW + 1)'(push_s);
  assign rp_s         = rp_r + (AW + 1)'(pop_s);
  assign full_s       = ((wp_s - rp_s) == DEPTH);
  assign push_entry_s = {rx_addr_r, rx_asm_r};
  // A push into the slot that becomes the head must be forwarded, the array is not yet written
  assign head_s       = (push_s && (wp_r == rp_s)) ? push_entry_s : mem_r[rp_s[AW-1:0]];

  // RX next-state
  always_comb begin
    rx_state_s = rx_state_r;
    case (rx_state_r)
      R_HEAD: begin
        if (rx_xfer_s && hdr_ok_s) rx_state_s = R_BODY;
        else                       rx_state_s = R_HEAD;
      end
      R_BODY: begin
        if (rx_xfer_s && (rx_cnt_r == LAST)) rx_state_s = R_TAIL;
        else                                 rx_state_s = R_BODY;
      end
      R_TAIL: begin
        if (rx_xfer_s) rx_state_s = R_HEAD;
        else           rx_state_s = R_TAIL;
      end
      default: rx_state_s = R_HEAD;
    endcase
  end

  // RX assembly, error pulses and flit_in_ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_r      <= R_HEAD;
      rx_cnt_r        <= '0;
      rx_asm_r        <= '0;
      rx_addr_r       <= '0;
      err_hdr_r       <= 1'b0;
      err_tail_r      <= 1'b0;
      flit_in_ready_r <= 1'b1;
    end else begin
      rx_state_r      <= rx_state_s;
      err_hdr_r       <= (rx_state_r == R_HEAD) && rx_xfer_s && !hdr_ok_s;
      err_tail_r      <= (rx_state_r == R_TAIL) && rx_xfer_s && (flit_in != TAIL);
      flit_in_ready_r <= (rx_state_s != R_TAIL) || !full_s;
      case (rx_state_r)
        R_HEAD: begin
          if (rx_xfer_s && hdr_ok_s) begin
            rx_addr_r <= flit_in[ADDR_W-1:0];
            rx_asm_r  <= '0;
            rx_cnt_r  <= '0;
          end
        end
        R_BODY: begin
          if (rx_xfer_s) begin
            rx_asm_r[FLIT_W*rx_cnt_r +: FLIT_W] <= flit_in;
            rx_cnt_r <= rx_cnt_r + 1'b1;
          end
        end
        default: rx_cnt_r <= rx_cnt_r;
      endcase
    end
  end

  // RX word FIFO with registered head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RX_DEPTH; i++) mem_r[i] <= '0;
      wp_r         <= '0;
      rp_r         <= '0;
      data_out_r   <= '0;
      data_dest_r  <= '0;
      data_valid_r <= 1'b0;
    end else begin
      if (push_s) mem_r[wp_r[AW-1:0]] <= push_entry_s;
      wp_r         <= wp_s;
      rp_r         <= rp_s;
      data_out_r   <= head_s[DATA_W-1:0];
      data_dest_r  <= head_s[EW-1:DATA_W];
      data_valid_r <= (wp_s != rp_s);
    end
  end

  assign proc_ready    = proc_ready_r;
  assign flit_out      = flit_out_r;
  assign flit_valid    = flit_valid_r;
  assign flit_in_ready = flit_in_ready_r;
  assign err_hdr       = err_hdr_r;
  assign err_tail      = err_tail_r;
  assign data_out      = data_out_r;
  assign data_dest     = data_dest_r;
  assign data_valid    = data_valid_r;

endmodule
